// File: rtl/pe_feeder.sv
// pe_feeder: buffers complex input words and feeds one PE chain head.
// Each frame is sent as an unbroken LOAD_NUM-word burst. The feeder then
// waits for ALPHA_NUM alpha words, or for a timeout, and idles one GAP
// cycle before the next frame may start. Alpha words are forwarded with
// one cycle of latency. Protocol errors and PE hangs are recorded in
// sticky flags.
module pe_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int LOAD_NUM   = 16,
   parameter int ALPHA_NUM  = 4,
   parameter int FIFO_DEPTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   input  logic [2*DATA_WIDTH-1:0] s_data,
   output logic                    s_ready,
   output logic                    dout_pe_v,
   output logic [2*DATA_WIDTH-1:0] dout_pe,
   input  logic                    din_alpha_v,
   input  logic [2*DATA_WIDTH-1:0] din_alpha,
   output logic                    m_alpha_v,
   output logic [2*DATA_WIDTH-1:0] m_alpha,
   output logic                    busy,
   output logic [15:0]             frame_cnt,
   output logic                    err_unexp,
   output logic                    err_timeout
);

   localparam int BW = 2*DATA_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(LOAD_NUM + 1);
   localparam int NW = $clog2(ALPHA_NUM + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] LOAD_CNT_C = CW'(LOAD_NUM);
   localparam logic [LW-1:0] LOAD_C     = LW'(LOAD_NUM);
   localparam logic [NW-1:0] ALPHA_LAST = NW'(ALPHA_NUM - 1);
   localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT, S_GAP} state_t;

   state_t                    state, state_nxt;
   logic [FIFO_DEPTH-1:0][BW-1:0] mem;
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             count;
   logic [LW-1:0]             bcnt;     // words issued in the current burst
   logic [NW-1:0]             acnt;     // alphas seen in the current WAIT
   logic [TW-1:0]             timer;    // cycles spent in the current WAIT
   logic                      push, pop, frame_done, tmo;

   assign s_ready = (count < DEPTH_C);
   assign push    = s_valid & s_ready;
   assign busy    = (state != S_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic. The burst pops its first word at the IDLE->BURST
   // edge, so the registered word appears on the bus the cycle after the
   // decision and the PE sees LOAD_NUM back-to-back valids.
   always_comb begin
      state_nxt  = state;
      pop        = 1'b0;
      frame_done = 1'b0;
      tmo        = 1'b0;
      case (state)
         S_IDLE: begin
            if (count >= LOAD_CNT_C) begin
               pop       = 1'b1;
               state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (bcnt < LOAD_C) pop = 1'b1;
            else               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A final alpha arriving on the last timer cycle still completes the frame.
            if (din_alpha_v && (acnt == ALPHA_LAST)) begin
               frame_done = 1'b1;
               state_nxt  = S_GAP;
            end else if (timer == TOUT_LAST) begin
               tmo       = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_data;
   end

   // FIFO pointers and occupancy. Pointers wrap naturally (depth is 2^AW).
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // PE data-in register: word valid only while popping, zero otherwise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_pe_v <= 1'b0;
         dout_pe   <= '0;
      end else begin
         dout_pe_v <= pop;
         dout_pe   <= pop ? mem[rd_ptr] : '0;
      end
   end

   // Burst word counter; restarts at 1 on the pop that opens the burst.
   always_ff @(posedge clk) begin
      if (!rst)      bcnt <= '0;
      else if (pop)  bcnt <= (state == S_IDLE) ? LW'(1) : bcnt + LW'(1);
   end

   // Alpha counter and hang timer, active only in WAIT and cleared elsewhere.
   always_ff @(posedge clk) begin
      if (!rst || state != S_WAIT) begin
         acnt  <= '0;
         timer <= '0;
      end else begin
         timer <= timer + TW'(1);
         if (din_alpha_v) acnt <= acnt + NW'(1);
      end
   end

   // Completed-frame counter and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_cnt   <= '0;
         err_unexp   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
         if (din_alpha_v && state != S_WAIT) err_unexp <= 1'b1;
         if (tmo) err_timeout <= 1'b1;
      end
   end

   // Alpha forwarding: one register stage in every state, data zeroed when idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_alpha_v <= 1'b0;
         m_alpha   <= '0;
      end else begin
         m_alpha_v <= din_alpha_v;
         m_alpha   <= din_alpha_v ? din_alpha : '0;
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed scenarios with random data, checked cycle by cycle
// against a behavioural model of the feeder (word queue, occupancy, frame
// and flag bookkeeping) plus a small PE model that returns alphas.
module tb_pe_feeder;

   localparam int LOAD_NUM   = 16;
   localparam int ALPHA_NUM  = 4;
   localparam int FIFO_DEPTH = 32;
   localparam int TIMEOUT    = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        dout_pe_v;
   logic [31:0] dout_pe;
   logic        din_alpha_v;
   logic [31:0] din_alpha;
   logic        m_alpha_v;
   logic [31:0] m_alpha;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        err_unexp;
   logic        err_timeout;

   pe_feeder #(
      .DATA_WIDTH(16), .LOAD_NUM(LOAD_NUM), .ALPHA_NUM(ALPHA_NUM),
      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .dout_pe_v(dout_pe_v), .dout_pe(dout_pe), .din_alpha_v(din_alpha_v),
      .din_alpha(din_alpha), .m_alpha_v(m_alpha_v), .m_alpha(m_alpha), .busy(busy),
      .frame_cnt(frame_cnt), .err_unexp(err_unexp), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // stimulus and reference-model state
   logic [31:0] src[$];      // words still to offer upstream
   logic [31:0] exp_q[$];    // accepted words not yet sent to the PE
   bit          push_en = 0;
   int          mcount = 0, run = 0, cyc = 0, gap_cyc = -10;
   int          last_push_cyc = 0, burst_start_cyc = 0, nready_low = 0, maxcnt = 0;
   bit          in_wait = 0, armed = 0, exp_unexp = 0, exp_timeout = 0, cfg_gaps = 0;
   int          wtick = 0, acnt = 0, exp_frames = 0;
   int          cfg_delay = 20, cfg_nalpha = 4, pe_delay = 0, alphas_left = 0;
   int          f_before = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit quiet();
      return src.size() == 0 && run == 0 && !in_wait && !armed &&
             mcount < LOAD_NUM && !busy && cyc > gap_cyc + 1;
   endfunction

   // One clock: update the model from what happened at the edge, check the
   // DUT against it, then drive the next cycle's inputs.
   task automatic tick();
      logic acc, p_av, p_busy, p_rst, p_wait;
      logic [31:0] acc_d, p_ad;
      int p_cnt;
      acc = s_valid && s_ready && rst;
      acc_d = s_data;
      if (s_valid && !s_ready) nready_low++;
      p_av = din_alpha_v; p_ad = din_alpha; p_busy = busy;
      p_rst = rst; p_wait = in_wait; p_cnt = mcount;
      @(posedge clk); #1;
      cyc++;
      chk("m_alpha_v", 32'(m_alpha_v), 32'(p_rst && p_av));
      chk("m_alpha", m_alpha, (p_rst && p_av) ? p_ad : 32'd0);
      if (!p_rst) begin
         exp_q.delete(); mcount = 0; run = 0; in_wait = 0; armed = 0;
         exp_frames = 0; exp_unexp = 0; exp_timeout = 0; gap_cyc = -10;
         chk("rst_dout_v", 32'(dout_pe_v), 32'd0);
         chk("rst_dout", dout_pe, 32'd0);
         chk("rst_s_ready", 32'(s_ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
         chk("rst_err_unexp", 32'(err_unexp), 32'd0);
         chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      end else begin
         if (acc) begin
            exp_q.push_back(acc_d); mcount++; src.delete(0); last_push_cyc = cyc;
         end
         if (p_av && !p_wait) exp_unexp = 1;
         if (p_wait) begin
            wtick++;
            if (p_av) acnt++;
            if (acnt == ALPHA_NUM) begin exp_frames++; in_wait = 0; gap_cyc = cyc; end
            else if (wtick == TIMEOUT) begin exp_timeout = 1; in_wait = 0; gap_cyc = cyc; end
         end
         if (!p_busy) chk("burst_start", 32'(dout_pe_v), 32'(p_cnt >= LOAD_NUM));
         if (dout_pe_v) begin
            chk("busy_burst", 32'(busy), 32'd1);
            chk("pop_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin chk("burst_word", dout_pe, exp_q[0]); exp_q.delete(0); end
            mcount--;
            if (run == 0) burst_start_cyc = cyc;
            run++;
            if (run == LOAD_NUM) begin armed = 1; pe_delay = cfg_delay; alphas_left = cfg_nalpha; end
         end else begin
            chk("dout_idle_zero", dout_pe, 32'd0);
            if (run != 0) begin
               chk("burst_len", 32'(run), 32'(LOAD_NUM));
               if (run == LOAD_NUM) begin in_wait = 1; wtick = 0; acnt = 0; end
               run = 0;
            end
         end
         if (in_wait) begin
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_dout_v", 32'(dout_pe_v), 32'd0);
         end
         if (cyc == gap_cyc) begin
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_dout_v", 32'(dout_pe_v), 32'd0);
         end
         if (cyc == gap_cyc + 1) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_dout_v", 32'(dout_pe_v), 32'd0);
         end
         chk("s_ready", 32'(s_ready), 32'(mcount < FIFO_DEPTH));
         chk("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
         chk("err_unexp", 32'(err_unexp), 32'(exp_unexp));
         chk("err_timeout", 32'(err_timeout), 32'(exp_timeout));
         if (mcount > maxcnt) maxcnt = mcount;
      end
      // drive next cycle
      if (push_en && src.size() > 0) begin s_valid = 1'b1; s_data = src[0]; end
      else begin s_valid = 1'b0; s_data = $urandom; end
      din_alpha_v = 1'b0;
      din_alpha   = $urandom;
      if (armed) begin
         if (pe_delay > 0) pe_delay--;
         else if (!cfg_gaps || $urandom_range(0, 2) != 0) begin
            din_alpha_v = 1'b1;
            alphas_left--;
            if (alphas_left == 0) armed = 0;
         end
      end
   endtask

   task automatic run_quiet(input int budget, input string tag);
      int n;
      n = 0;
      do begin tick(); n++; end while (!quiet() && n < budget);
      chk({tag, "_settled"}, 32'(quiet()), 32'd1);
   endtask

   task automatic push_random(input int n);
      for (int i = 0; i < n; i++) src.push_back($urandom);
   endtask

   initial begin
      rst = 1'b0; s_valid = 1'b0; s_data = '0; din_alpha_v = 1'b0; din_alpha = '0;
      // reset
      tick(); tick();
      rst = 1'b1;
      tick();

      // single frame with the fixed 0x00010001.. pattern
      for (int i = 1; i <= LOAD_NUM; i++) src.push_back({16'(i), 16'(i)});
      cfg_delay = 20; cfg_nalpha = 4; cfg_gaps = 0; push_en = 1;
      run_quiet(400, "single");
      chk("single_start", 32'(burst_start_cyc), 32'(last_push_cyc + 1));
      chk("single_frames", 32'(frame_cnt), 32'd1);

      // partial fill: 15 words never start a burst
      push_random(LOAD_NUM - 1);
      repeat (LOAD_NUM - 1 + 50) tick();
      chk("partial_dout_v", 32'(dout_pe_v), 32'd0);
      chk("partial_busy", 32'(busy), 32'd0);
      push_random(1);
      run_quiet(400, "partial");
      chk("partial_start", 32'(burst_start_cyc), 32'(last_push_cyc + 1));
      chk("partial_frames", 32'(frame_cnt), 32'd2);

      // back-to-back frames, s_valid held high for 32 words
      nready_low = 0;
      push_random(2 * LOAD_NUM);
      run_quiet(800, "b2b");
      chk("b2b_ready_low", 32'(nready_low), 32'd0);
      chk("b2b_frames", 32'(frame_cnt), 32'd4);
      chk("b2b_flags", {30'd0, err_unexp, err_timeout}, 32'd0);

      // continuous streaming through bursts with slow PE; FIFO fills up
      cfg_delay = 40; cfg_gaps = 1; maxcnt = 0;
      push_random(4 * LOAD_NUM);
      run_quiet(3000, "stream");
      chk("stream_full", 32'(maxcnt), 32'(FIFO_DEPTH));
      chk("stream_frames", 32'(frame_cnt), 32'd8);

      // hang: only 3 alphas return
      cfg_delay = 10; cfg_nalpha = 3; cfg_gaps = 0;
      f_before = exp_frames;
      push_random(LOAD_NUM);
      run_quiet(2000, "hang");
      chk("hang_timeout", 32'(err_timeout), 32'd1);
      chk("hang_frames", 32'(frame_cnt), 32'(f_before));
      chk("hang_unexp_clear", 32'(err_unexp), 32'd0);
      // late 4th alpha outside WAIT
      din_alpha_v = 1'b1; din_alpha = 32'hDEAD_0004;
      tick();
      chk("late_unexp", 32'(err_unexp), 32'd1);
      chk("late_fwd", m_alpha, 32'hDEAD_0004);
      chk("late_busy", 32'(busy), 32'd0);
      tick();

      // reset at burst word 7
      cfg_nalpha = 4;
      push_random(LOAD_NUM);
      begin
         int n;
         n = 0;
         while (run != 7 && n < 200) begin tick(); n++; end
         chk("mid_reach_word7", 32'(run), 32'd7);
      end
      rst = 1'b0; push_en = 0; src.delete();
      tick();
      chk("mid_rst_dout_v", 32'(dout_pe_v), 32'd0);
      chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
      chk("mid_rst_flags", {30'd0, err_unexp, err_timeout}, 32'd0);
      rst = 1'b1; push_en = 1;
      tick(); tick();
      chk("mid_no_burst", 32'(dout_pe_v), 32'd0);
      push_random(LOAD_NUM);
      run_quiet(400, "fresh");
      chk("fresh_frames", 32'(frame_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
